// File: rtl/adam_tgt_pause_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adam_tgt_pause_ctrl_pkg
// Description : Configuration defaults shared by the target pause controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adam_tgt_pause_ctrl_pkg;

    localparam int          CFG_ADDR_WIDTH    = 32;
    localparam logic [31:0] CFG_RST_BOOT_ADDR = 32'h0000_1000;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adam_tgt_otx_cnt.sv
`default_nettype none
// ============================================================================
// Module      : adam_tgt_otx_cnt
// Description : Up/down saturating count of in-flight core bus requests.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_tgt_otx_cnt
    import adam_tgt_pause_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] r_count;
    logic             w_inc;
    logic             w_dec;

    // A response with nothing in flight is dropped rather than underflowing.
    assign w_inc   = i_inc & ~o_full;
    assign w_dec   = i_dec & ~o_empty;
    assign o_full  = (r_count == c_MAX);
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adam_tgt_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adam_tgt_pause_ctrl
// Description : Turns syscfg target reset/pause/boot address into core reset,
//               fetch enable and boot vector; pause ack waits for bus drain.
// Revision    : 1.0 - initial release
// ============================================================================
module adam_tgt_pause_ctrl
    import adam_tgt_pause_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = CFG_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RST_BOOT_ADDR   = ADDR_WIDTH'(CFG_RST_BOOT_ADDR),
    parameter int                    MAX_OUTSTANDING = 4,
    parameter int                    DRAIN_TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tgt_rst,
    input  logic                  tgt_pause_req,
    output logic                  tgt_pause_ack,
    input  logic [ADDR_WIDTH-1:0] tgt_boot_addr,
    output logic                  core_rst,
    output logic                  core_fetch_en,
    output logic [ADDR_WIDTH-1:0] core_boot_addr,
    input  logic                  bus_req_valid,
    input  logic                  bus_req_ready_i,
    output logic                  bus_req_ready_o,
    input  logic                  bus_rsp_valid,
    output logic                  drain_timeout
);

    localparam logic [1:0] c_ST_PAUSED = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    localparam int                   c_TIMER_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic                 c_TIMEOUT_EN = (DRAIN_TIMEOUT != 0);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST =
        c_TIMER_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_ack;
    logic                  r_fetch_en;
    logic                  r_core_rst;
    logic [ADDR_WIDTH-1:0] r_boot_addr;
    logic [c_TIMER_W-1:0]  r_timer;
    logic                  r_drain_timeout;

    logic                  w_ack_nxt;
    logic                  w_fetch_en_nxt;
    logic [c_TIMER_W-1:0]  w_timer_nxt;
    logic                  w_drain_timeout_nxt;
    logic                  w_cnt_clr;
    logic                  w_accept;
    logic                  w_otx_full;
    logic                  w_otx_empty;
    logic                  w_drained;
    logic                  w_timeout_hit;

    assign bus_req_ready_o = bus_req_ready_i & r_fetch_en & ~w_otx_full;
    assign w_accept        = bus_req_valid & bus_req_ready_o;
    assign w_drained       = w_otx_empty & ~w_accept;
    assign w_timeout_hit   = c_TIMEOUT_EN & (r_timer == c_TIMER_LAST);

    assign tgt_pause_ack   = r_ack;
    assign core_fetch_en   = r_fetch_en;
    assign core_rst        = r_core_rst;
    assign core_boot_addr  = r_boot_addr;
    assign drain_timeout   = r_drain_timeout;

    adam_tgt_otx_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_otx_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_accept),
        .i_dec   (bus_rsp_valid),
        .o_full  (w_otx_full),
        .o_empty (w_otx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_PAUSED;
            r_ack           <= 1'b1;
            r_fetch_en      <= 1'b0;
            r_core_rst      <= 1'b1;
            r_boot_addr     <= RST_BOOT_ADDR;
            r_timer         <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ack           <= w_ack_nxt;
            r_fetch_en      <= w_fetch_en_nxt;
            r_core_rst      <= tgt_rst;
            r_timer         <= w_timer_nxt;
            r_drain_timeout <= w_drain_timeout_nxt;
            if (tgt_rst) begin
                r_boot_addr <= tgt_boot_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (tgt_rst) begin
            w_state_nxt = c_ST_PAUSED;
        end else begin
            case (r_state)
                c_ST_PAUSED: if (!tgt_pause_req) w_state_nxt = c_ST_RUN;
                c_ST_RUN:    if (tgt_pause_req)  w_state_nxt = c_ST_DRAIN;
                c_ST_DRAIN: begin
                    if (!tgt_pause_req) begin
                        w_state_nxt = c_ST_RUN;
                    end else if (w_drained || w_timeout_hit) begin
                        w_state_nxt = c_ST_PAUSED;
                    end
                end
                default:     w_state_nxt = c_ST_PAUSED;
            endcase
        end
    end

    always_comb begin
        w_ack_nxt           = r_ack;
        w_fetch_en_nxt      = r_fetch_en;
        w_timer_nxt         = r_timer;
        w_drain_timeout_nxt = r_drain_timeout;
        w_cnt_clr           = 1'b0;
        if (tgt_rst) begin
            w_ack_nxt           = tgt_pause_req;
            w_fetch_en_nxt      = 1'b0;
            w_drain_timeout_nxt = 1'b0;
            w_cnt_clr           = 1'b1;
        end else begin
            case (r_state)
                c_ST_PAUSED: begin
                    if (!tgt_pause_req) begin
                        w_ack_nxt      = 1'b0;
                        w_fetch_en_nxt = 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (tgt_pause_req) begin
                        w_fetch_en_nxt = 1'b0;
                        w_timer_nxt    = '0;
                    end
                end
                c_ST_DRAIN: begin
                    if (!tgt_pause_req) begin
                        w_fetch_en_nxt = 1'b1;
                    end else if (w_drained) begin
                        w_ack_nxt = 1'b1;
                    end else if (w_timeout_hit) begin
                        // Forced ack: in-flight requests are abandoned.
                        w_ack_nxt           = 1'b1;
                        w_drain_timeout_nxt = 1'b1;
                        w_cnt_clr           = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_fetch_en_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adam_tgt_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adam_tgt_pause_ctrl
// Description : Vector table, directed corner sequences and random stimulus
//               against a behavioural model of the pause controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adam_tgt_pause_ctrl;

    localparam int          c_MAXO     = 4;
    localparam int          c_TMO      = 16;
    localparam logic [31:0] c_RST_BOOT = 32'h0001_0000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        tgt_rst = 1'b1;
    logic        req     = 1'b1;
    logic        valid   = 1'b0;
    logic        rdy_i   = 1'b0;
    logic        rsp     = 1'b0;
    logic [31:0] boot    = 32'h8000_0000;
    logic        ack, core_rst, fetch_en, rdy_o, dto;
    logic [31:0] core_boot;

    always #5 clk = ~clk;

    adam_tgt_pause_ctrl #(
        .ADDR_WIDTH      (32),
        .RST_BOOT_ADDR   (c_RST_BOOT),
        .MAX_OUTSTANDING (c_MAXO),
        .DRAIN_TIMEOUT   (c_TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tgt_rst         (tgt_rst),
        .tgt_pause_req   (req),
        .tgt_pause_ack   (ack),
        .tgt_boot_addr   (boot),
        .core_rst        (core_rst),
        .core_fetch_en   (fetch_en),
        .core_boot_addr  (core_boot),
        .bus_req_valid   (valid),
        .bus_req_ready_i (rdy_i),
        .bus_req_ready_o (rdy_o),
        .bus_rsp_valid   (rsp),
        .drain_timeout   (dto)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: mode 0 = paused, 1 = running, 2 = draining.
    int          m_mode, m_out, m_timer;
    bit          m_ack, m_fetch, m_crst, m_to;
    logic [31:0] m_boot;

    typedef struct packed {
        bit trst, preq, bvalid, brdy, brsp;
        bit e_ack, e_fetch, e_crst;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_ready();
        return rdy_i && m_fetch && (m_out < c_MAXO);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ack = 1; m_crst = 1; m_fetch = 0;
        m_boot = c_RST_BOOT; m_out = 0; m_timer = 0; m_to = 0;
    endtask

    task automatic model_step();
        int old_out;
        bit acc, rspc;
        if (rst) begin
            model_reset();
            return;
        end
        old_out = m_out;
        acc     = valid && model_ready();
        rspc    = rsp && (old_out > 0);
        m_crst  = tgt_rst;
        if (tgt_rst) begin
            m_boot = boot; m_mode = 0; m_ack = req; m_fetch = 0; m_out = 0; m_to = 0;
            return;
        end
        m_out = old_out + int'(acc) - int'(rspc);
        case (m_mode)
            0: if (!req) begin m_ack = 0; m_fetch = 1; m_mode = 1; end
            1: if (req) begin m_fetch = 0; m_timer = 0; m_mode = 2; end
            default: begin
                if (!req) begin
                    m_fetch = 1; m_mode = 1;
                end else if (old_out == 0 && !acc) begin
                    m_ack = 1; m_mode = 0;
                end else if (c_TMO != 0 && m_timer == c_TMO - 1) begin
                    m_ack = 1; m_out = 0; m_to = 1; m_mode = 0;
                end else begin
                    m_timer++;
                end
            end
        endcase
    endtask

    // One clock: check comb ready, advance model, compare registered outputs.
    task automatic tick();
        #1;
        chk("ready_o", 32'(rdy_o), 32'(model_ready()));
        model_step();
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(m_ack));
        chk("core_rst", 32'(core_rst), 32'(m_crst));
        chk("fetch_en", 32'(fetch_en), 32'(m_fetch));
        chk("boot_addr", core_boot, m_boot);
        chk("drain_timeout", 32'(dto), 32'(m_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ack_cyc;
        model_reset();

        tbl[0]  = '{1,1,0,0,0, 1,0,1};
        tbl[1]  = '{1,1,0,0,0, 1,0,1};
        tbl[2]  = '{0,0,0,0,0, 0,1,0};
        tbl[3]  = '{0,0,0,0,0, 0,1,0};
        tbl[4]  = '{0,1,0,0,0, 0,0,0};
        tbl[5]  = '{0,1,0,0,0, 1,0,0};
        tbl[6]  = '{0,1,0,0,0, 1,0,0};
        tbl[7]  = '{0,0,0,0,0, 0,1,0};
        tbl[8]  = '{0,0,0,0,0, 0,1,0};
        tbl[9]  = '{0,1,1,1,0, 0,0,0};
        tbl[10] = '{0,1,0,0,0, 0,0,0};
        tbl[11] = '{0,1,0,0,1, 0,0,0};
        tbl[12] = '{0,1,0,0,0, 1,0,0};
        tbl[13] = '{0,0,0,0,0, 0,1,0};

        // Reset state
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'd1);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_fetch_en", 32'(fetch_en), 32'd0);
        chk("rst_boot_addr", core_boot, c_RST_BOOT);
        chk("rst_drain_timeout", 32'(dto), 32'd0);
        rst = 1'b0;

        // Vector table: release, pause with nothing in flight, pause with one.
        for (int i = 0; i < 14; i++) begin
            tgt_rst = tbl[i].trst; req = tbl[i].preq; valid = tbl[i].bvalid;
            rdy_i = tbl[i].brdy;   rsp = tbl[i].brsp;
            tick();
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
            chk($sformatf("vec%0d_fetch", i), 32'(fetch_en), 32'(tbl[i].e_fetch));
            chk($sformatf("vec%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].e_crst));
        end
        chk("boot_latched", core_boot, 32'h8000_0000);

        // Three accepted requests, pause, responses at +4/+6/+9.
        boot = 32'hDEAD_0000; valid = 1; rdy_i = 1;
        repeat (3) tick();
        chk("otx_three", 32'(dut.u_otx_cnt.r_count), 32'd3);
        valid = 0; req = 1; ack_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            rsp = (i == 4 || i == 6 || i == 9);
            if (i >= 1) valid = 1;
            tick();
            chk("no_accept_after_pause", 32'(rdy_o), 32'd0);
            if (ack && ack_cyc < 0) ack_cyc = i + 1;
            if (ack_cyc >= 0) break;
        end
        rsp = 0; valid = 0;
        chk("drain_ack_cycle", 32'(ack_cyc), 32'd11);
        chk("boot_frozen", core_boot, 32'h8000_0000);

        // Fill to MAX_OUTSTANDING, then one response reopens ready.
        req = 0; tick();
        valid = 1; rdy_i = 1;
        repeat (4) tick();
        chk("full_ready_o", 32'(rdy_o), 32'd0);
        valid = 0; rsp = 1; tick(); rsp = 0;
        chk("ready_after_rsp", 32'(rdy_o), 32'd1);

        // Leave one request unanswered and pause: forced ack.
        rsp = 1; repeat (2) tick(); rsp = 0;
        req = 1; ack_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack && ack_cyc < 0) ack_cyc = i + 1;
            if (ack_cyc >= 0) break;
        end
        chk("timeout_ack_cycle", 32'(ack_cyc), 32'd17);
        chk("timeout_flag", 32'(dto), 32'd1);
        chk("timeout_otx_clear", 32'(dut.u_otx_cnt.r_count), 32'd0);
        req = 0; tick();
        chk("timeout_sticky", 32'(dto), 32'd1);

        // Abandoned pause.
        valid = 1; tick(); valid = 0;
        req = 1; repeat (2) tick();
        req = 0; tick();
        chk("abandon_ack", 32'(ack), 32'd0);
        chk("abandon_fetch", 32'(fetch_en), 32'd1);
        rsp = 1; tick(); rsp = 0;

        // Target reset mid-drain with two in flight.
        valid = 1; repeat (2) tick(); valid = 0;
        req = 1; repeat (2) tick();
        tgt_rst = 1; tick();
        chk("trst_ack", 32'(ack), 32'd1);
        chk("trst_fetch", 32'(fetch_en), 32'd0);
        chk("trst_otx_clear", 32'(dut.u_otx_cnt.r_count), 32'd0);
        chk("trst_dto_clear", 32'(dto), 32'd0);
        chk("trst_boot", core_boot, 32'hDEAD_0000);
        tgt_rst = 0; req = 0; tick();
        chk("trst_resume_fetch", 32'(fetch_en), 32'd1);
        chk("trst_resume_core_rst", 32'(core_rst), 32'd0);

        // Random traffic; middle stretch starves responses to reach timeouts.
        for (int i = 0; i < 700; i++) begin
            tgt_rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) req = ~req;
            valid = 1'($urandom_range(0, 1));
            rdy_i = ($urandom_range(0, 3) != 0);
            if (i >= 250 && i < 450) rsp = ($urandom_range(0, 24) == 0);
            else rsp = ($urandom_range(0, 2) == 0);
            boot = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
